// File: rtl/diff_demo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : diff_demo_pkg
//  Description : Shared types and constants for the PE array datapath:
//                PE step encoding, weight-slice selector, window-sequencer
//                FSM states, weight-buffer sizing and the phase helpers.
//  Contents    : CONF_WT_BUF_DEPTH, WT_ADDR_WIDTH, PE_PROCESS_WINDOW,
//                PE_state_t, PE_weight_mode_t, pe_seq_state_t,
//                phase_mode(), last_phase()
//  Revision    : 1.0 - initial release
// ============================================================================
package diff_demo_pkg;

    // Depth of the weight buffer in words.
    localparam int CONF_WT_BUF_DEPTH = 512;
    localparam int WT_ADDR_WIDTH     = $clog2(CONF_WT_BUF_DEPTH);

    // Output columns produced by the PE array per processed window group.
    localparam int PE_PROCESS_WINDOW = 4;

    // PE step within one weight slice; IDLE means the array is not stepping.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ONE   = 3'd1,
        TWO   = 3'd2,
        THREE = 3'd3,
        FOUR  = 3'd4,
        FIVE  = 3'd5,
        SIX   = 3'd6
    } PE_state_t;

    // Slice of the weight word in use. A..D split a 5x5 kernel, E is a
    // complete 3x3 kernel and doubles as the inactive value.
    typedef enum logic [2:0] {
        E_MODE = 3'd0,
        A_MODE = 3'd1,
        B_MODE = 3'd2,
        C_MODE = 3'd3,
        D_MODE = 3'd4
    } PE_weight_mode_t;

    // Window sequencer FSM.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } pe_seq_state_t;

    // Weight slice used by a given phase of a window.
    function automatic PE_weight_mode_t phase_mode(input logic       kernel_mode,
                                                   input logic [1:0] phase_idx);
        PE_weight_mode_t mode;
        mode = E_MODE;
        if (kernel_mode) begin
            case (phase_idx)
                2'd0:    mode = A_MODE;
                2'd1:    mode = B_MODE;
                2'd2:    mode = C_MODE;
                default: mode = D_MODE;
            endcase
        end
        return mode;
    endfunction

    // Index of the final phase in a window: one phase for 3x3, four for 5x5.
    function automatic logic [1:0] last_phase(input logic kernel_mode);
        return kernel_mode ? 2'd3 : 2'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_window_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : pe_window_seq_if
//  Description : Job/control bundle between a job issuer and the PE window
//                sequencer.
//  Ports       : master - drives start, kernel_mode, num_windows,
//                         wt_base_addr, stall; observes the rest
//                slave  - the sequencer; drives wt_buf_rd_en,
//                         wt_buf_rd_addr, pe_state, wt_mode, pe_en, busy, done
//  Revision    : 1.0 - initial release
// ============================================================================
interface pe_window_seq_if
    import diff_demo_pkg::*;
#(
    parameter int WT_ADDR_W = WT_ADDR_WIDTH,
    parameter int WIN_CNT_W = 16
) ();

    logic                 start;
    logic                 kernel_mode;
    logic [WIN_CNT_W-1:0] num_windows;
    logic [WT_ADDR_W-1:0] wt_base_addr;
    logic                 stall;

    logic                 wt_buf_rd_en;
    logic [WT_ADDR_W-1:0] wt_buf_rd_addr;
    PE_state_t            pe_state;
    PE_weight_mode_t      wt_mode;
    logic                 pe_en;
    logic                 busy;
    logic                 done;

    modport master (
        output start, kernel_mode, num_windows, wt_base_addr, stall,
        input  wt_buf_rd_en, wt_buf_rd_addr, pe_state, wt_mode, pe_en, busy, done
    );

    modport slave (
        input  start, kernel_mode, num_windows, wt_base_addr, stall,
        output wt_buf_rd_en, wt_buf_rd_addr, pe_state, wt_mode, pe_en, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/pe_window_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pe_window_seq
//  Description : Sequences the PE array through a job of num_windows window
//                groups. Each window runs one phase (3x3) or four phases
//                (5x5); a phase is one weight-buffer read cycle followed by
//                six PE compute steps. Weights restart at wt_base_addr for
//                every window.
//  Ports       : clk   - clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - pe_window_seq_if.slave (job request, stall, weight
//                        read strobe/address, PE step/mode/enable, busy/done)
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_window_seq
    import diff_demo_pkg::*;
#(
    parameter int WT_ADDR_W = $clog2(CONF_WT_BUF_DEPTH),
    parameter int WIN_CNT_W = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    pe_window_seq_if.slave      bus
);

    pe_seq_state_t        state;

    // Job configuration captured on the accepted start.
    logic                 kmode;
    logic [WIN_CNT_W-1:0] nwin;
    logic [WT_ADDR_W-1:0] base;

    logic [WIN_CNT_W-1:0] win_idx;
    logic [1:0]           phase_idx;

    // Registered outputs. load_q/run_q are the ungated strobes; stall masks
    // them combinationally at the port.
    logic                 load_q;
    logic                 run_q;
    logic [WT_ADDR_W-1:0] rd_addr;
    PE_state_t            pe_state_q;
    PE_weight_mode_t      wt_mode_q;
    logic                 busy_q;
    logic                 done_q;

    logic [1:0]           next_phase;
    logic                 last_phase_hit;
    logic                 last_win_hit;

    assign next_phase     = phase_idx + 2'd1;
    assign last_phase_hit = (phase_idx == last_phase(kmode));
    assign last_win_hit   = (win_idx == nwin - WIN_CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            kmode      <= 1'b0;
            nwin       <= '0;
            base       <= '0;
            win_idx    <= '0;
            phase_idx  <= 2'd0;
            load_q     <= 1'b0;
            run_q      <= 1'b0;
            rd_addr    <= '0;
            pe_state_q <= IDLE;
            wt_mode_q  <= E_MODE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        kmode     <= bus.kernel_mode;
                        nwin      <= bus.num_windows;
                        base      <= bus.wt_base_addr;
                        win_idx   <= '0;
                        phase_idx <= 2'd0;
                        busy_q    <= 1'b1;
                        if (bus.num_windows == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= S_LOAD;
                            load_q  <= 1'b1;
                            rd_addr <= bus.wt_base_addr;
                        end
                    end
                end

                S_LOAD: begin
                    // Holding here while stalled re-presents the read once
                    // the stall drops.
                    if (!bus.stall) begin
                        state      <= S_RUN;
                        load_q     <= 1'b0;
                        rd_addr    <= '0;
                        run_q      <= 1'b1;
                        pe_state_q <= ONE;
                        wt_mode_q  <= phase_mode(kmode, phase_idx);
                    end
                end

                S_RUN: begin
                    if (!bus.stall) begin
                        if (pe_state_q != SIX) begin
                            pe_state_q <= PE_state_t'(pe_state_q + 3'd1);
                        end else begin
                            run_q      <= 1'b0;
                            pe_state_q <= IDLE;
                            wt_mode_q  <= E_MODE;
                            if (!last_phase_hit) begin
                                phase_idx <= next_phase;
                                state     <= S_LOAD;
                                load_q    <= 1'b1;
                                rd_addr   <= base + WT_ADDR_W'(next_phase);
                            end else if (!last_win_hit) begin
                                // New window reuses the same weights.
                                win_idx   <= win_idx + WIN_CNT_W'(1);
                                phase_idx <= 2'd0;
                                state     <= S_LOAD;
                                load_q    <= 1'b1;
                                rd_addr   <= base;
                            end else begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    // Completion is never held back by stall.
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.wt_buf_rd_en   = load_q & ~bus.stall;
    assign bus.wt_buf_rd_addr = rd_addr;
    assign bus.pe_state       = pe_state_q;
    assign bus.wt_mode        = wt_mode_q;
    assign bus.pe_en          = run_q & ~bus.stall;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_window_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_window_seq
//  Description : Directed self-checking bench for pe_window_seq. Every cycle
//                of each job is compared against hand-derived expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_window_seq;
    import diff_demo_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pe_window_seq_if #(.WT_ADDR_W(9), .WIN_CNT_W(16)) bus ();

    pe_window_seq #(.WT_ADDR_W(9), .WIN_CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_rd_en"},   32'(bus.wt_buf_rd_en),   32'd0);
        check_eq({tag, "_rd_addr"}, 32'(bus.wt_buf_rd_addr), 32'd0);
        check_eq({tag, "_pe_state"},32'(bus.pe_state),       32'(IDLE));
        check_eq({tag, "_wt_mode"}, 32'(bus.wt_mode),        32'(E_MODE));
        check_eq({tag, "_pe_en"},   32'(bus.pe_en),          32'd0);
        check_eq({tag, "_busy"},    32'(bus.busy),           32'd0);
        check_eq({tag, "_done"},    32'(bus.done),           32'd0);
    endtask

    // Present a job for one edge, then scramble the inputs so the job can
    // only proceed from the latched copy.
    task automatic start_job(input logic km, input logic [15:0] n, input logic [8:0] base);
        bus.kernel_mode  = km;
        bus.num_windows  = n;
        bus.wt_base_addr = base;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
        bus.kernel_mode  = ~km;
        bus.num_windows  = 16'd7;
        bus.wt_base_addr = 9'h155;
    endtask

    task automatic expect_load(input string tag, input logic [8:0] addr);
        check_eq({tag, "_ld_rd_en"},   32'(bus.wt_buf_rd_en),   32'd1);
        check_eq({tag, "_ld_rd_addr"}, 32'(bus.wt_buf_rd_addr), 32'(addr));
        check_eq({tag, "_ld_pe_en"},   32'(bus.pe_en),          32'd0);
        check_eq({tag, "_ld_pe_state"},32'(bus.pe_state),       32'(IDLE));
        check_eq({tag, "_ld_busy"},    32'(bus.busy),           32'd1);
        check_eq({tag, "_ld_done"},    32'(bus.done),           32'd0);
        tick();
    endtask

    task automatic expect_run(input string tag, input PE_weight_mode_t mode);
        for (int s = 1; s <= 6; s++) begin
            check_eq({tag, "_run_pe_state"}, 32'(bus.pe_state),       32'(s));
            check_eq({tag, "_run_pe_en"},    32'(bus.pe_en),          32'd1);
            check_eq({tag, "_run_wt_mode"},  32'(bus.wt_mode),        32'(mode));
            check_eq({tag, "_run_rd_en"},    32'(bus.wt_buf_rd_en),   32'd0);
            check_eq({tag, "_run_rd_addr"},  32'(bus.wt_buf_rd_addr), 32'd0);
            check_eq({tag, "_run_done"},     32'(bus.done),           32'd0);
            tick();
        end
    endtask

    task automatic expect_done(input string tag);
        check_eq({tag, "_done"},       32'(bus.done),         32'd1);
        check_eq({tag, "_done_busy"},  32'(bus.busy),         32'd1);
        check_eq({tag, "_done_pe_en"}, 32'(bus.pe_en),        32'd0);
        check_eq({tag, "_done_rd_en"}, 32'(bus.wt_buf_rd_en), 32'd0);
        tick();
        check_idle({tag, "_after"});
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.kernel_mode  = 1'b0;
        bus.num_windows  = '0;
        bus.wt_base_addr = '0;
        bus.stall        = 1'b0;
        tick();
        tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        // 3x3, two windows from address 10; a start mid-job must be ignored.
        start_job(1'b0, 16'd2, 9'd10);
        expect_load("k3n2_w0", 9'd10);
        bus.start = 1'b1;
        expect_run("k3n2_w0", E_MODE);
        bus.start = 1'b0;
        expect_load("k3n2_w1", 9'd10);
        expect_run("k3n2_w1", E_MODE);
        expect_done("k3n2");

        // 5x5, one window, addresses run up to the top of the buffer.
        start_job(1'b1, 16'd1, 9'd508);
        expect_load("k5_a", 9'd508); expect_run("k5_a", A_MODE);
        expect_load("k5_b", 9'd509); expect_run("k5_b", B_MODE);
        expect_load("k5_c", 9'd510); expect_run("k5_c", C_MODE);
        expect_load("k5_d", 9'd511); expect_run("k5_d", D_MODE);
        expect_done("k5");

        // 5x5, two windows, address wraps and restarts at base per window.
        start_job(1'b1, 16'd2, 9'd510);
        for (int w = 0; w < 2; w++) begin
            expect_load("wrap_a", 9'd510); expect_run("wrap_a", A_MODE);
            expect_load("wrap_b", 9'd511); expect_run("wrap_b", B_MODE);
            expect_load("wrap_c", 9'd0);   expect_run("wrap_c", C_MODE);
            expect_load("wrap_d", 9'd1);   expect_run("wrap_d", D_MODE);
        end
        expect_done("wrap");

        // Stall three cycles while the array sits at step THREE.
        start_job(1'b0, 16'd1, 9'd5);
        expect_load("strun", 9'd5);
        for (int s = 1; s <= 2; s++) begin
            check_eq("strun_pre_state", 32'(bus.pe_state), 32'(s));
            check_eq("strun_pre_en",    32'(bus.pe_en),    32'd1);
            tick();
        end
        bus.stall = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            check_eq("strun_hold_state", 32'(bus.pe_state), 32'(THREE));
            check_eq("strun_hold_en",    32'(bus.pe_en),    32'd0);
            check_eq("strun_hold_mode",  32'(bus.wt_mode),  32'(E_MODE));
            check_eq("strun_hold_done",  32'(bus.done),     32'd0);
            tick();
        end
        bus.stall = 1'b0;
        #1;
        for (int s = 3; s <= 6; s++) begin
            check_eq("strun_post_state", 32'(bus.pe_state), 32'(s));
            check_eq("strun_post_en",    32'(bus.pe_en),    32'd1);
            tick();
        end
        expect_done("strun");

        // Stall on the load cycle; the read is withheld then issued once.
        start_job(1'b0, 16'd1, 9'd7);
        bus.stall = 1'b1;
        #1;
        for (int j = 0; j < 2; j++) begin
            check_eq("stld_rd_en",    32'(bus.wt_buf_rd_en), 32'd0);
            check_eq("stld_busy",     32'(bus.busy),         32'd1);
            check_eq("stld_pe_state", 32'(bus.pe_state),     32'(IDLE));
            tick();
        end
        bus.stall = 1'b0;
        #1;
        expect_load("stld", 9'd7);
        check_eq("stld_single_pulse", 32'(bus.wt_buf_rd_en), 32'd0);
        expect_run("stld", E_MODE);
        // Stall during the done cycle does not hold it.
        bus.stall = 1'b1;
        #1;
        check_eq("stdone_done", 32'(bus.done), 32'd1);
        tick();
        check_eq("stdone_clear", 32'(bus.done), 32'd0);
        check_eq("stdone_busy",  32'(bus.busy), 32'd0);
        bus.stall = 1'b0;
        #1;

        // Zero windows: done immediately; start during busy is ignored.
        start_job(1'b0, 16'd0, 9'd3);
        check_eq("n0_done",  32'(bus.done),         32'd1);
        check_eq("n0_busy",  32'(bus.busy),         32'd1);
        check_eq("n0_rd_en", 32'(bus.wt_buf_rd_en), 32'd0);
        check_eq("n0_pe_en", 32'(bus.pe_en),        32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_idle("n0_ignored_start");
        tick();
        check_idle("n0_stay_idle");

        // Reset in the middle of a run aborts with no done pulse.
        start_job(1'b0, 16'd1, 9'd3);
        expect_load("rst", 9'd3);
        check_eq("rst_pre_state", 32'(bus.pe_state), 32'(ONE));
        tick();
        rst_n = 1'b0;
        tick();
        check_idle("rst_abort");
        rst_n = 1'b1;
        tick();
        check_idle("rst_no_done");

        // A fresh job after the abort runs normally.
        start_job(1'b1, 16'd1, 9'd0);
        expect_load("rerun_a", 9'd0); expect_run("rerun_a", A_MODE);
        expect_load("rerun_b", 9'd1); expect_run("rerun_b", B_MODE);
        expect_load("rerun_c", 9'd2); expect_run("rerun_c", C_MODE);
        expect_load("rerun_d", 9'd3); expect_run("rerun_d", D_MODE);
        expect_done("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_window_seq.md
PE_WINDOW_SEQ -- requirements
Module: pe_window_seq

Interface
REQ-001 SHALL have parameter WT_ADDR_W, default $clog2(CONF_WT_BUF_DEPTH) (=9), weight-buffer address width.
REQ-002 SHALL have parameter WIN_CNT_W, default 16, width of window count.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle job request; honoured only when busy=0.
REQ-006 kernel_mode  input  1  0: 3*3, 1: 5*5; sampled on accepted start.
REQ-007 num_windows  input  WIN_CNT_W  PE_PROCESS_WINDOW groups to process; sampled on accepted start.
REQ-008 wt_base_addr  input  WT_ADDR_W  first weight word of job; sampled on accepted start.
REQ-009 stall  input  1  downstream PSUM FIFO full; freezes sequencer.
REQ-010 wt_buf_rd_en  output  1  weight-buffer read strobe (1-cycle read latency).
REQ-011 wt_buf_rd_addr  output  WT_ADDR_W  weight-buffer read address.
REQ-012 pe_state  output  PE_state_t  PE step (IDLE, ONE..SIX).
REQ-013 wt_mode  output  PE_weight_mode_t  slice of PE_weight_t in use.
REQ-014 pe_en  output  1  PE array computes this cycle.
REQ-015 busy  output  1  job in progress.
REQ-016 done  output  1  one-cycle job-complete pulse.

Function
REQ-017 FSM states SHALL be S_IDLE, S_LOAD, S_RUN, S_DONE.
REQ-018 Phase list per window SHALL be {E_MODE} for kernel_mode=0, {A_MODE,B_MODE,C_MODE,D_MODE} in that order for kernel_mode=1.
REQ-019 S_IDLE + start SHALL latch config, reset window/phase counters, go to S_LOAD next cycle; if num_windows=0 go to S_DONE instead.
REQ-020 S_LOAD SHALL last one unstalled cycle with wt_buf_rd_en=1, wt_buf_rd_addr=wt_base_addr+phase_index (modulo 2^WT_ADDR_W), then go to S_RUN.
REQ-021 S_RUN SHALL last six unstalled cycles, pe_state stepping ONE..SIX, pe_en=1, wt_mode=current phase.
REQ-022 After SIX: next phase -> S_LOAD; last phase with windows remaining -> phase_index=0, window+1, S_LOAD; last phase of last window -> S_DONE.
REQ-023 Weight address SHALL restart at wt_base_addr each window (weights reused across windows).
REQ-024 S_DONE SHALL last one cycle with done=1, then S_IDLE.
REQ-025 busy SHALL be 1 in every state except S_IDLE; start while busy=1 SHALL be ignored.
REQ-026 stall=1 SHALL hold FSM, counters, pe_state, wt_mode; SHALL force wt_buf_rd_en=0 and pe_en=0 that cycle; S_LOAD read reissues once stall drops.
REQ-027 stall SHALL NOT delay S_DONE or affect S_IDLE.
REQ-028 Outside S_RUN: pe_state=IDLE, pe_en=0, wt_mode=E_MODE; outside S_LOAD: wt_buf_rd_en=0, wt_buf_rd_addr=0.
REQ-029 Cycle count without stall SHALL be 1 + 7*P*N cycles of busy (P phases, N windows) before done; start at edge k gives S_LOAD at cycle k+1.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force S_IDLE, counters 0, all outputs 0/IDLE/E_MODE, aborting any job without done.
REQ-031 Outputs SHALL be registered; no combinational path start/stall -> outputs except REQ-026 gating of rd_en/pe_en.

Structure
REQ-032 FSM enum pe_seq_state_t and WT_ADDR_WIDTH constant SHALL be added to diff_demo_pkg; PE_state_t, PE_weight_mode_t, PE_PROCESS_WINDOW reused from it.
REQ-033 Block SHALL be flat; no sub-module.

Verification
REQ-034 kernel_mode=0, N=2, base=10, no stall -> rd_en at cycles k+1, k+8 addr 10 both; pe_state ONE..SIX twice in E_MODE; done at k+15.
REQ-035 kernel_mode=1, N=1, base=508 -> addrs 508,509,510,511, modes A,B,C,D each six steps; done at k+29.
REQ-036 stall high 3 cycles during S_RUN at THREE -> pe_state holds THREE, pe_en=0 three cycles; done delayed by 3.
REQ-037 stall high on S_LOAD cycle -> rd_en=0 while stalled, one rd_en pulse after release.
REQ-038 N=0 -> done at k+1, no rd_en/pe_en; start during busy ignored.
REQ-039 rst_n low mid-S_RUN -> next cycle all outputs reset, no done pulse; new start works normally.
